add_sub_seq: RTL and testbench

//  Digit-serial multi-precision add/subtract sequencer. It reuses one 4-bit add/sub slice over WIDTH/4 cycles.

---
 rtl/add_seq_pkg.sv | 17 +
 rtl/add_seq_fa.sv | 15 +
 rtl/add_sub_slice4.sv | 38 +++
 rtl/add_sub_seq.sv | 170 +++++++++++++++++
 tb/tb_add_sub_seq.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared constants, FSM state type and digit-count helper for add_sub_seq
package add_seq_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_seq_state_t;

    // Number of DIGIT_W-bit digits processed per operation.
    function automatic int ndig(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/add_seq_fa.sv
// rtl/add_seq_fa.sv - single-bit full adder cell
//   a, b, cin : addends and carry in
//   s, cout   : sum bit and carry out
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_sub_slice4.sv
// rtl/add_sub_slice4.sv - combinational 4-bit ripple add/subtract slice built from fa cells
//   a[3:0], b[3:0] : digit operands (b is inverted when sub=1)
//   sub            : 1 selects a + ~b (the +1 arrives through cin)
//   cin            : carry/borrow from the previous digit
//   sum[3:0], cout : digit result and carry out of bit 3
//   c3             : carry into bit 3, used for signed overflow on the top digit
module add_sub_slice4
    import add_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               sub,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               c3
);

    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   c;

    assign b_eff = b ^ {DIGIT_W{sub}};
    assign c[0]  = cin;

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_bit
        fa u_fa (
            .a    (a[i]),
            .b    (b_eff[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[DIGIT_W];
    assign c3   = c[DIGIT_W-1];

endmodule

// File: rtl/add_sub_seq.sv
// rtl/add_sub_seq.sv - digit-serial multi-precision add/subtract sequencer (one 4-bit slice, WIDTH/4 cycles)
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start_valid/start_ready     : operand handshake carrying A, B, Subtract
//   result_valid/result_ready   : result handshake carrying Sum, Cout (and Overflow)
//   busy                        : high while digits are being processed
//   Overflow                    : signed overflow, present only when ADD_SEQ_OVERFLOW_EN is defined
module add_sub_seq
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Subtract,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
`ifdef ADD_SEQ_OVERFLOW_EN
    output logic             Overflow,
`endif
    output logic             busy
);

    localparam int NDIG  = ndig(WIDTH);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_bad_width
        $error("add_sub_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    add_seq_state_t     state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sub_q, sub_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [DIGIT_W-1:0] a_dig, b_dig, s_dig;
    logic               s_cout, s_c3;
    logic               accept;

    assign start_ready  = (state_q == IDLE) | ((state_q == DONE) & result_ready);
    assign accept       = start_valid & start_ready;
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q == RUN);
    assign Sum          = sum_q;
    assign Cout         = cout_q;

    // Select the current digit of each latched operand.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int d = 0; d < NDIG; d++) begin
            if (idx_q == IDX_W'(d)) begin
                a_dig = a_q[d*DIGIT_W +: DIGIT_W];
                b_dig = b_q[d*DIGIT_W +: DIGIT_W];
            end
        end
    end

    add_sub_slice4 u_slice (
        .a    (a_dig),
        .b    (b_dig),
        .sub  (sub_q),
        .cin  (carry_q),
        .sum  (s_dig),
        .cout (s_cout),
        .c3   (s_c3)
    );

`ifdef ADD_SEQ_OVERFLOW_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && idx_q == LAST_IDX) begin
            ovf_d = s_c3 ^ s_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Overflow = ovf_q;
`else
    logic unused_c3;
    assign unused_c3 = s_c3;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            RUN: begin
                for (int d = 0; d < NDIG; d++) begin
                    if (idx_q == IDX_W'(d)) begin
                        sum_d[d*DIGIT_W +: DIGIT_W] = s_dig;
                    end
                end
                carry_d = s_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = s_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance is only possible from IDLE or a consumed DONE, so it
        // overrides the transitions above and gives back-to-back operation.
        if (accept) begin
            a_d     = A;
            b_d     = B;
            sub_d   = Subtract;
            carry_d = Subtract;
            idx_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_add_sub_seq.sv
// tb/tb_add_sub_seq.sv - directed self-checking bench for add_sub_seq (WIDTH=16)
module tb_add_sub_seq;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Subtract;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] Sum;
    logic        Cout;
    logic        busy;
`ifdef ADD_SEQ_OVERFLOW_EN
    logic        Overflow;
`endif

    int total = 0;
    int bad   = 0;

    add_sub_seq #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .A            (A),
        .B            (B),
        .Subtract     (Subtract),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .Sum          (Sum),
        .Cout         (Cout),
`ifdef ADD_SEQ_OVERFLOW_EN
        .Overflow     (Overflow),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present an operation at a negedge; return once it has been accepted.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub);
        start_valid = 1'b1;
        A           = a;
        B           = b;
        Subtract    = sub;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        A           = 16'($urandom);
        B           = 16'($urandom);
        Subtract    = 1'($urandom);
    endtask

    // Count edges from acceptance until result_valid, bounded.
    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        while (!result_valid && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check({tag, "_latency"}, cyc, 4);
    endtask

    task automatic consume();
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf);
        check({tag, "_start_ready"}, start_ready, 1);
        issue(a, b, sub);
        check({tag, "_busy"}, busy, 1);
        wait_result(tag);
        check({tag, "_sum"}, Sum, exp_sum);
        check({tag, "_cout"}, Cout, exp_cout);
`ifdef ADD_SEQ_OVERFLOW_EN
        check({tag, "_ovf"}, Overflow, exp_ovf);
`else
        if (exp_ovf === 1'bx) $error("FAIL %s_ovf_arg: observed=x expected=0/1", tag);
`endif
        consume();
        check({tag, "_rv_clear"}, result_valid, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        A            = '0;
        B            = '0;
        Subtract     = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_result_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", Sum, 0);
        check("rst_cout", Cout, 0);
`ifdef ADD_SEQ_OVERFLOW_EN
        check("rst_ovf", Overflow, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_start_ready", start_ready, 1);

        // Basic add, subtract with and without borrow, full carry ripple.
        do_op("add1",  16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        do_op("sub1",  16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
        do_op("sub2",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("ripple",16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Result held while consumer stalls, then back-to-back accept.
        issue(16'h1111, 16'h2222, 1'b0);
        wait_result("hold");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_sum", Sum, 16'h3333);
            check("hold_cout", Cout, 0);
            check("hold_rv", result_valid, 1);
            check("hold_start_ready", start_ready, 0);
        end
        result_ready = 1'b1;
        #1;
        check("b2b_start_ready", start_ready, 1);
        issue(16'h0100, 16'h0200, 1'b0);
        result_ready = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_rv", result_valid, 0);
        wait_result("b2b");
        check("b2b_sum", Sum, 16'h0300);
        check("b2b_cout", Cout, 0);
        consume();

        // Reset mid-operation abandons it immediately.
        issue(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_rv", result_valid, 0);
        check("midrst_sum", Sum, 0);
        check("midrst_cout", Cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("postrst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Signed overflow cases (flag checked only when the feature is built).
        do_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("noovf",   16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
